crc_frame_encoder: RTL
======================

// Module: crc_frame_encoder
// PURPOSE
//  Parametrised frame buffer and CRC encoder. Next generation of the fixed 4-deep, 8-bit input capture stage.
//  - Accepts one frame of DATA_W words (startin...stopin), buffers up to DEPTH words and updates a CRC per word.
//  - Replays the frame on dataout, then appends the CRC as CRC_W/DATA_W words.
//  - Sits between the packet source and the serializer in the CRC datapath.
// PARAMETERS
//  DATA_W  8             word width in bits; CRC_W % DATA_W == 0 required (elaboration $error otherwise)
//  DEPTH   16            max words per frame; >= 1
//  CRC_W   32            CRC width
//  POLY    32'h04C11DB7  generator polynomial, implicit top bit
//  INIT    32'hFFFFFFFF  CRC register value at frame start
//  XOROUT  32'h00000000  XOR applied to the final CRC before emission
// PORTS
//  clk       in   1       rising-edge clock
//  reset     in   1       asynchronous, active-high reset
//  startin   in   1       qualifies first word of a frame (valid only with pushin)
//  stopin    in   1       qualifies last word of a frame (valid only with pushin)
//  pushin    in   1       input word valid
//  datain    in   DATA_W  input word
//  busy      out  1       high while emitting; pushin is dropped when high
//  startout  out  1       first output word of frame (with pushout)
//  endout    out  1       last output word, i.e. last CRC word (with pushout)
//  pushout   out  1       output word valid
//  dataout   out  DATA_W  output word
//  err       out  1       one-cycle pulse: overflow, dropped word, or restarted frame
// BEHAVIOUR
//  Reset (async, all registers):
//   - busy, startout, endout, pushout, err = 0; dataout = 0.
//   - crc = INIT, wcount = 0, state = IDLE, buffer cleared.
//  CRC arithmetic:
//   - Non-reflected, MSB-first, bitwise over each DATA_W word:
//     fb = crc[CRC_W-1]^d[i]; crc = {crc[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
//   - Emitted value = crc ^ XOROUT, most significant DATA_W chunk first.
//  FSM IDLE:
//   - pushin&startin: store word 0, crc = INIT updated with word, wcount = 1.
//     Next state is EMIT_DATA if stopin, else FILL.
//   - pushin without startin: word dropped silently (no err).
//  FSM FILL:
//   - pushin: store at wcount, update crc, wcount++.
//   - pushin&stopin: -> EMIT_DATA.
//   - pushin&startin: discard current frame, err pulse, restart as in IDLE with this word.
//   - pushin when wcount==DEPTH and no stopin: frame aborted, err pulse, -> IDLE, nothing emitted.
//   - stopin at word DEPTH is legal.
//  FSM EMIT_DATA:
//   - busy=1; pushout=1 every cycle; dataout = buf[rd].
//   - startout on rd==0.
//   - After wcount words -> EMIT_CRC.
//  FSM EMIT_CRC:
//   - busy=1; pushout=1 for CRC_W/DATA_W cycles; endout on last chunk.
//   - Then -> IDLE with busy=0 in the following cycle.
//  Timing:
//   - Outputs are registered.
//   - First pushout occurs the cycle after the stop word is sampled.
//   - Frame of N words gives N+CRC_W/DATA_W contiguous pushout cycles, no bubbles.
//  Pushin while busy: word dropped, err pulse; state and crc unaffected.
//  Reset mid-frame or mid-emit: immediate return to reset values; partial frame lost, no endout.
//  Buffer is never read past wcount; stale contents beyond wcount are irrelevant.
// TESTING
//  1. Defaults; push "123456789" (0x31..0x39), startin on 0x31, stopin on 0x39
//     -> 9 data words, then 0x03,0x76,0xE6,0xE7; startout on 0x31, endout on 0xE7.
//  2. INIT=0; single word 0x00 with startin&stopin together
//     -> pushout 5 cycles: 0x00,0x00,0x00,0x00,0x00; startout cycle 1, endout cycle 5.
//  3. Defaults; 17 words with no stopin
//     -> err pulse on word 17, no pushout; next valid frame encodes correctly.
//  4. Pushin during EMIT_DATA of test 1 frame -> err pulse, emitted stream identical to test 1.
//  5. New startin after 3 words of a frame -> err pulse; only second frame emitted, CRC over it alone.
//  6. Assert reset during EMIT_CRC -> pushout/busy low that cycle, no endout; next frame correct.

Source files
------------

// File: rtl/crc_frame_encoder.sv
// crc_frame_encoder: captures one frame of DATA_W words (startin..stopin) into a
// DEPTH-deep buffer while folding each word into a running CRC. It then replays the
// frame on dataout, followed by the CRC split into CRC_W/DATA_W words, MSB chunk first.
// All outputs are registered. The first output word appears the cycle after the stop
// word is sampled, and every frame streams without bubbles.
module crc_frame_encoder #(
  parameter int               DATA_W = 8,
  parameter int               DEPTH  = 16,
  parameter int               CRC_W  = 32,
  parameter logic [CRC_W-1:0] POLY   = 32'h04C11DB7,
  parameter logic [CRC_W-1:0] INIT   = 32'hFFFFFFFF,
  parameter logic [CRC_W-1:0] XOROUT = 32'h00000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              startin,
  input  logic              stopin,
  input  logic              pushin,
  input  logic [DATA_W-1:0] datain,
  output logic              busy,
  output logic              startout,
  output logic              endout,
  output logic              pushout,
  output logic [DATA_W-1:0] dataout,
  output logic              err
);

  localparam int NCHUNK = CRC_W / DATA_W;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int CHK_W  = $clog2(NCHUNK + 1);
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C      = CNT_W'(DEPTH);
  localparam logic [CHK_W-1:0] NCHUNK_C     = CHK_W'(NCHUNK);
  localparam logic [CHK_W-1:0] LAST_CHUNK_C = CHK_W'(NCHUNK - 1);

  // The CRC must split into a whole number of output words, and the buffer needs at least one entry.
  if ((CRC_W % DATA_W) != 0) begin : gBadCrcWidth
    $error("crc_frame_encoder: CRC_W must be a multiple of DATA_W");
  end
  if (DEPTH < 1) begin : gBadDepth
    $error("crc_frame_encoder: DEPTH must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, FILL, EMIT_DATA, EMIT_CRC} state_t;

  state_t              r_state, w_state;
  logic [DATA_W-1:0]   r_buf [0:DEPTH-1];
  logic [CRC_W-1:0]    r_crc, w_crc;
  logic [CNT_W-1:0]    r_wcount, w_wcount;
  logic [CNT_W-1:0]    r_rd, w_rd;
  logic [CHK_W-1:0]    r_chunk, w_chunk;
  logic                r_busy, w_busy;
  logic                r_startout, w_startout;
  logic                r_endout, w_endout;
  logic                r_pushout, w_pushout;
  logic [DATA_W-1:0]   r_dataout, w_dataout;
  logic                r_err, w_err;
  logic                w_wrEn;
  logic [CNT_W-1:0]    w_wrAddr;
  logic                w_doStart;
  logic [CRC_W-1:0]    w_crcFirst, w_crcAcc, w_crcOut;

  // MSB-first, non-reflected CRC update over one input word.
  function automatic logic [CRC_W-1:0] crcUpdate(input logic [CRC_W-1:0] c,
                                                 input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] x;
    logic             fb;
    x = c;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = x[CRC_W-1] ^ d[i];
      x  = {x[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return x;
  endfunction

  // Chunk k of the final CRC, where chunk 0 is the most significant DATA_W bits.
  function automatic logic [DATA_W-1:0] crcChunk(input logic [CRC_W-1:0] c,
                                                 input logic [CHK_W-1:0] k);
    logic [CRC_W-1:0] sh;
    sh = c >> ((NCHUNK - 1 - int'(k)) * DATA_W);
    return sh[DATA_W-1:0];
  endfunction

  assign w_crcFirst = crcUpdate(INIT, datain);
  assign w_crcAcc   = crcUpdate(r_crc, datain);
  assign w_crcOut   = r_crc ^ XOROUT;

  // Next-state and next-output logic. The outputs computed here are registered on the next edge.
  always_comb begin
    w_state    = r_state;
    w_crc      = r_crc;
    w_wcount   = r_wcount;
    w_rd       = r_rd;
    w_chunk    = r_chunk;
    w_busy     = r_busy;
    w_startout = 1'b0;
    w_endout   = 1'b0;
    w_pushout  = r_pushout;
    w_dataout  = r_dataout;
    w_err      = 1'b0;
    w_wrEn     = 1'b0;
    w_wrAddr   = r_wcount;
    w_doStart  = 1'b0;

    case (r_state)
      IDLE: begin
        if (pushin && startin) begin
          w_doStart = 1'b1;
        end
      end
      FILL: begin
        if (pushin) begin
          if (startin) begin
            w_doStart = 1'b1;
            w_err     = 1'b1;
          end else if (r_wcount == DEPTH_C) begin
            w_err    = 1'b1;
            w_state  = IDLE;
            w_wcount = '0;
          end else begin
            w_wrEn   = 1'b1;
            w_wrAddr = r_wcount;
            w_crc    = w_crcAcc;
            w_wcount = r_wcount + 1'b1;
            if (stopin) begin
              w_state    = EMIT_DATA;
              w_busy     = 1'b1;
              w_pushout  = 1'b1;
              w_startout = 1'b1;
              w_dataout  = r_buf[0];
              w_rd       = CNT_W'(1);
            end
          end
        end
      end
      EMIT_DATA: begin
        w_err = pushin;
        if (r_rd < r_wcount) begin
          w_dataout = r_buf[r_rd[AW-1:0]];
          w_rd      = r_rd + 1'b1;
        end else begin
          w_dataout = crcChunk(w_crcOut, '0);
          w_chunk   = CHK_W'(1);
          w_endout  = (NCHUNK == 1);
          w_state   = EMIT_CRC;
        end
      end
      EMIT_CRC: begin
        w_err = pushin;
        if (r_chunk < NCHUNK_C) begin
          w_dataout = crcChunk(w_crcOut, r_chunk);
          w_chunk   = r_chunk + 1'b1;
          w_endout  = (r_chunk == LAST_CHUNK_C);
        end else begin
          w_state   = IDLE;
          w_busy    = 1'b0;
          w_pushout = 1'b0;
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase

    // A start word always begins a fresh frame: word 0 and a CRC seeded from INIT.
    if (w_doStart) begin
      w_wrEn   = 1'b1;
      w_wrAddr = '0;
      w_crc    = w_crcFirst;
      w_wcount = CNT_W'(1);
      if (stopin) begin
        w_state    = EMIT_DATA;
        w_busy     = 1'b1;
        w_pushout  = 1'b1;
        w_startout = 1'b1;
        w_dataout  = datain;
        w_rd       = CNT_W'(1);
      end else begin
        w_state = FILL;
      end
    end
  end

  // State, CRC, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_crc      <= INIT;
      r_wcount   <= '0;
      r_rd       <= '0;
      r_chunk    <= '0;
      r_busy     <= 1'b0;
      r_startout <= 1'b0;
      r_endout   <= 1'b0;
      r_pushout  <= 1'b0;
      r_dataout  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_crc      <= w_crc;
      r_wcount   <= w_wcount;
      r_rd       <= w_rd;
      r_chunk    <= w_chunk;
      r_busy     <= w_busy;
      r_startout <= w_startout;
      r_endout   <= w_endout;
      r_pushout  <= w_pushout;
      r_dataout  <= w_dataout;
      r_err      <= w_err;
    end
  end

  // Frame buffer. It is written only while capturing and read only below wcount.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_wrEn) begin
      r_buf[w_wrAddr[AW-1:0]] <= datain;
    end
  end

  assign busy     = r_busy;
  assign startout = r_startout;
  assign endout   = r_endout;
  assign pushout  = r_pushout;
  assign dataout  = r_dataout;
  assign err      = r_err;

endmodule
